red_pitaya_counter_frontend: RTL
================================

# red_pitaya_counter_frontend

Input conditioning stage placed directly upstream of the counter's `inputs` port. It synchronises raw asynchronous detector lines into `i_clk` and applies per-channel polarity inversion and edge selection. It enforces a per-channel programmable dead time (holdoff). It delivers single-cycle count pulses, plus clean levels for trigger/gate use, over its own system-bus register window.

## Interface

Parameters:
- `CHN`, default 4: number of input channels, 1..8.
- `HW`, default 16: holdoff counter width in bits.

Ports:
- `i_clk`, in, 1: system clock, 125 MHz.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `inputs_raw`, in, CHN: asynchronous detector inputs.
- `o_pulse`, out, CHN: one-cycle count pulse per accepted edge; feeds the counter's `inputs`.
- `o_level`, out, CHN: synchronised, polarity-corrected level; used for trigger/gate.
- `sys_addr`, in, 32: bus address; only `[7:0]` is decoded.
- `sys_wdata`, in, 32: bus write data.
- `sys_wen`, in, 1: write strobe, one cycle.
- `sys_ren`, in, 1: read strobe, one cycle.
- `sys_rdata`, out, 32: read data.
- `sys_err`, out, 1: tied 0.
- `sys_ack`, out, 1: one-cycle acknowledge.

## Operation

Registers (reset value 0 for all):
- 0x00 `inv[CHN-1:0]`: bit n=1 inverts channel n.
- 0x04 `fall[CHN-1:0]`: bit n=0 counts rising edges, 1 counts falling edges (after inversion).
- 0x08 + 4·n `holdoff_n[HW-1:0]`: dead time in cycles for channel n.
- Unmapped address: write ignored, read returns 0, ack still given.

Per-channel datapath:
- 2-FF synchroniser, then XOR with `inv[n]` to give `lvl`, then history register `lvl_d`.
- `edge` = `lvl & ~lvl_d` if `fall[n]`=0, else `~lvl & lvl_d`.
- Holdoff state machine: `HOLD_IDLE` when `hold_cnt`=0, `HOLD_BUSY` otherwise.
  - In IDLE, an edge asserts `o_pulse[n]` and loads `hold_cnt <= holdoff_n`.
  - In BUSY, `hold_cnt` decrements and edges are discarded.
  - `holdoff_n`=0 means every edge is accepted.
  - The earliest next accepted edge is `holdoff_n`+1 cycles after the previous pulse.
- Writing `holdoff_n` during BUSY does not alter the running `hold_cnt`; the new value applies at the next load.
- Writing `inv` or `fall` may create a synthetic edge on `lvl`. It is counted like any real edge (documented behaviour).

Reset and priming:
- `i_rst` clears the synchronisers, `lvl_d`, `hold_cnt`, all registers, `o_pulse`, `o_level`, `sys_ack` and `sys_rdata` immediately.
- A 2-bit prime counter suppresses `edge` for the first 3 cycles after reset release, so an input already high at release does not produce a pulse.
- Reset asserted mid-holdoff aborts the holdoff.

## Timing

- Input transition to `o_level`: 2–3 `i_clk` edges (synchroniser uncertainty).
- Input transition to `o_pulse`: 3–4 cycles; pulse width is exactly 1 cycle.
- Minimum resolvable input pulse: 1 cycle high and 1 cycle low. Shorter pulses may be lost.
- Bus:
  - `sys_ack` is registered and goes high exactly 1 cycle after `sys_wen`/`sys_ren`.
  - `sys_rdata` is valid in the same cycle as `sys_ack` and holds until the next read.
  - A write takes effect in the cycle `sys_ack` is high.
  - Simultaneous `sys_wen` and `sys_ren`: the write wins, and `rdata` returns the old value.
- All outputs are registered; there is no combinational path from any input.

## Configuration

Macro: `COUNTER_FRONTEND_STATS_EN`.

Defined:
- Adds per-channel 32-bit raw edge counters at 0x40 + 4·n.
- These count every detected edge, including those discarded in holdoff.
- They saturate at 0xFFFFFFFF.
- Any write to 0x40 + 4·n clears counter n. An edge arriving in the same cycle as the clear is lost.
- Reset value is 0.

Not defined:
- The counters are absent.
- 0x40.. behaves as unmapped: reads return 0, ack is given.

## Test plan

- Reset release with `inputs_raw[0]`=1 held → `o_pulse` stays 0 for 20 cycles; `o_level[0]`=1 within 3 cycles of release.
- `inputs_raw[0]` toggling every 10 cycles, holdoff 0, rising mode → 1 pulse per 20 cycles, pulse 3–4 cycles after each rising edge, width 1.
- `inputs_raw[1]` high 2 of every 5 cycles, `holdoff_1`=20, observed over 100 cycles (20 edges) → exactly 4 pulses, spaced 25 cycles apart.
- `inv`=0x1, `fall`=0x1 on channel 0 with the same stimulus as above → pulses on raw rising edges; `o_level[0]` is inverted relative to the raw input.
- Bus: write 0x08 = 0x1234 then read it back → `rdata`=0x1234, ack 1 cycle after strobe; read 0xFC → 0 with ack; `sys_err` stays 0 throughout.
- With `COUNTER_FRONTEND_STATS_EN` defined, using the holdoff stimulus above → 0x44 reads 20; write 0x44 → next read returns 0; assert `i_rst` mid-holdoff → `hold_cnt` cleared, and the first edge after priming produces a pulse.

Source files
------------

// File: rtl/red_pitaya_counter_frontend.sv
// Counter input front end: 2-FF synchronisers, per-channel inversion, edge select and holdoff dead time.
// Outputs are one-cycle count pulses and clean levels. The block also has its own system-bus register window.
// Define COUNTER_FRONTEND_STATS_EN to add saturating raw edge counters at 0x40 + 4*n.
module red_pitaya_counter_frontend #(
  parameter int CHN = 4,
  parameter int HW  = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [CHN-1:0] inputs_raw,
  output logic [CHN-1:0] o_pulse,
  output logic [CHN-1:0] o_level,
  input  logic [31:0]    sys_addr,
  input  logic [31:0]    sys_wdata,
  input  logic           sys_wen,
  input  logic           sys_ren,
  output logic [31:0]    sys_rdata,
  output logic           sys_err,
  output logic           sys_ack
);

  localparam logic [0:0] HOLD_IDLE = 1'b0;
  localparam logic [0:0] HOLD_BUSY = 1'b1;

  logic [CHN-1:0] sync_q, sync_d;
  logic [CHN-1:0] lvl_q, lvl_d;
  logic [CHN-1:0] hist_q, hist_d;
  logic [CHN-1:0] pulse_q, pulse_d;
  logic [CHN-1:0] inv_q, inv_d;
  logic [CHN-1:0] fall_q, fall_d;
  logic [1:0]     prime_q, prime_d;
  logic [HW-1:0]  holdoff_q [CHN];
  logic [HW-1:0]  holdoff_d [CHN];
  logic [HW-1:0]  hold_cnt_q [CHN];
  logic [HW-1:0]  hold_cnt_d [CHN];
  logic [0:0]     hold_st [CHN];
  logic           ack_q, ack_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           primed;
  logic [CHN-1:0] edge_det;
  logic [5:0]     widx;
  logic           word_ok;
  logic           unused_bits;

`ifdef COUNTER_FRONTEND_STATS_EN
  logic [31:0]    stat_q [CHN];
  logic [31:0]    stat_d [CHN];
`endif

  assign widx        = sys_addr[7:2];
  assign word_ok     = (sys_addr[1:0] == 2'b00);
  assign unused_bits = ^{sys_addr[31:8], sys_wdata};

  // Edges are ignored until the pipeline has refilled after reset, so a line already high at release is not counted.
  assign primed = (prime_q == 2'd3);
  // XOR with fall turns a falling edge into a rising one, so one expression serves both modes.
  assign edge_det = primed ? ((lvl_q ^ fall_q) & ~(hist_q ^ fall_q)) : '0;

  // Synchroniser, polarity correction, level history and prime counter.
  always_comb begin
    sync_d  = inputs_raw;
    lvl_d   = sync_q ^ inv_q;
    hist_d  = lvl_q;
    prime_d = primed ? prime_q : prime_q + 2'd1;
  end

  // Holdoff: an edge seen while idle emits a pulse and starts the dead time; edges while busy are dropped.
  always_comb begin
    pulse_d = '0;
    for (int n = 0; n < CHN; n++) begin
      hold_st[n]    = (hold_cnt_q[n] == '0) ? HOLD_IDLE : HOLD_BUSY;
      hold_cnt_d[n] = hold_cnt_q[n];
      if (hold_st[n] == HOLD_BUSY) begin
        hold_cnt_d[n] = hold_cnt_q[n] - HW'(1);
      end else if (edge_det[n]) begin
        pulse_d[n]    = 1'b1;
        hold_cnt_d[n] = holdoff_q[n];
      end
    end
  end

  // Register window: reads sample the pre-write value, so a simultaneous write/read returns the old contents.
  always_comb begin
    inv_d     = inv_q;
    fall_d    = fall_q;
    holdoff_d = holdoff_q;
    ack_d     = sys_wen | sys_ren;
    rdata_d   = rdata_q;
    if (sys_ren) begin
      rdata_d = '0;
      if (word_ok) begin
        if (widx == 6'd0) rdata_d[CHN-1:0] = inv_q;
        if (widx == 6'd1) rdata_d[CHN-1:0] = fall_q;
        for (int n = 0; n < CHN; n++) begin
          if (widx == 6'(n + 2)) rdata_d[HW-1:0] = holdoff_q[n];
`ifdef COUNTER_FRONTEND_STATS_EN
          if (widx == 6'(n + 16)) rdata_d = stat_q[n];
`endif
        end
      end
    end
    if (sys_wen && word_ok) begin
      if (widx == 6'd0) inv_d  = sys_wdata[CHN-1:0];
      if (widx == 6'd1) fall_d = sys_wdata[CHN-1:0];
      for (int n = 0; n < CHN; n++) begin
        if (widx == 6'(n + 2)) holdoff_d[n] = sys_wdata[HW-1:0];
      end
    end
  end

`ifdef COUNTER_FRONTEND_STATS_EN
  // Raw edge counters: count every detected edge, saturate at all-ones; a clear write takes priority over an edge.
  always_comb begin
    for (int n = 0; n < CHN; n++) begin
      stat_d[n] = stat_q[n];
      if (sys_wen && word_ok && (widx == 6'(n + 16))) begin
        stat_d[n] = '0;
      end else if (edge_det[n] && (stat_q[n] != 32'hFFFF_FFFF)) begin
        stat_d[n] = stat_q[n] + 32'd1;
      end
    end
  end

  // Raw edge counter state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stat_q <= '{default: '0};
    end else begin
      stat_q <= stat_d;
    end
  end
`endif

  // All datapath, holdoff and bus state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sync_q     <= '0;
      lvl_q      <= '0;
      hist_q     <= '0;
      pulse_q    <= '0;
      inv_q      <= '0;
      fall_q     <= '0;
      prime_q    <= '0;
      holdoff_q  <= '{default: '0};
      hold_cnt_q <= '{default: '0};
      ack_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      sync_q     <= sync_d;
      lvl_q      <= lvl_d;
      hist_q     <= hist_d;
      pulse_q    <= pulse_d;
      inv_q      <= inv_d;
      fall_q     <= fall_d;
      prime_q    <= prime_d;
      holdoff_q  <= holdoff_d;
      hold_cnt_q <= hold_cnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
    end
  end

  assign o_pulse   = pulse_q;
  assign o_level   = lvl_q;
  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = 1'b0;

endmodule
